decode_queue_stage: RTL

Registered instruction-decode stage for the mini-MIPS pipeline, the successor to the combinational decoder. Fetched instructions are buffered in a parametrised FIFO and decoded into a registered control bundle with a valid/ready handshake on both sides. The stage adds load-use bubble insertion, flush, and a saturating stall counter. It sits between fetch and register-read/execute.

---
 rtl/decode_queue_stage_pkg.sv | 165 ++++++++++++++++
 rtl/decode_queue_stage_if.sv | 35 +++
 rtl/decode_queue_stage_fifo.sv | 56 +++++
 rtl/decode_queue_stage.sv | 103 ++++++++++
 4 files changed

// File: rtl/decode_queue_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mips_decode_pkg                                              |
// | Description : Opcode/funct/ALU codes, the packed control bundle and the    |
// |               decode functions for the mini-MIPS decode queue stage.       |
// |               Macro DECODE_FP_EN enables decoding of opcodes 110000-110111. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mips_decode_pkg;

  localparam int CTRL_W = 18;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BR_A  = 6'b001010;
  localparam logic [5:0] OP_BR_B  = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101000;
  localparam logic [5:0] OP_ADD_S = 6'b110000;
  localparam logic [5:0] OP_SUB_S = 6'b110001;
  localparam logic [5:0] OP_CEQ_S = 6'b110010;
  localparam logic [5:0] OP_CLT_S = 6'b110011;
  localparam logic [5:0] OP_CLE_S = 6'b110100;
  localparam logic [5:0] OP_MOV_S = 6'b110101;
  localparam logic [5:0] OP_MFC1  = 6'b110110;
  localparam logic [5:0] OP_MTC1  = 6'b110111;

  // R-type function codes (madd/maddu/mul/sla live in the SPECIAL space here)
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SLA   = 6'b000001;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MUL   = 6'b011000;
  localparam logic [5:0] F_MADD  = 6'b011100;
  localparam logic [5:0] F_MADDU = 6'b011101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_MADD  = 4'b0011;
  localparam logic [3:0] ALU_MADDU = 4'b0100;
  localparam logic [3:0] ALU_MUL   = 4'b0101;
  localparam logic [3:0] ALU_AND   = 4'b0110;
  localparam logic [3:0] ALU_OR    = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1001;
  localparam logic [3:0] ALU_SLT   = 4'b1010;
  localparam logic [3:0] ALU_SLTU  = 4'b1011;
  localparam logic [3:0] ALU_LUI   = 4'b1100;
  localparam logic [3:0] ALU_SLL   = 4'b1110;
  localparam logic [3:0] ALU_SRL   = 4'b1111;

  // Control bundle, MSB first
  typedef struct packed {
    logic       illegal;
    logic       mtc1;
    logic       mfc1;
    logic       is_float;
    logic [1:0] jump_src;
    logic       jump;
    logic       branch;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_write;
  } ctrl_t;

  // Main decoder: opcode + funct to control bundle
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        case (funct)
          F_ADD, F_ADDU: c.alu_op = ALU_ADD;
          F_SUB, F_SUBU: c.alu_op = ALU_SUB;
          F_MADD:        c.alu_op = ALU_MADD;
          F_MADDU:       c.alu_op = ALU_MADDU;
          F_MUL:         c.alu_op = ALU_MUL;
          F_AND:         c.alu_op = ALU_AND;
          F_OR:          c.alu_op = ALU_OR;
          F_NOR:         c.alu_op = ALU_NOR;
          F_XOR:         c.alu_op = ALU_XOR;
          F_SLT:         c.alu_op = ALU_SLT;
          F_SLTU:        c.alu_op = ALU_SLTU;
          F_SLL, F_SLA:  c.alu_op = ALU_SLL;
          F_SRL, F_SRA:  c.alu_op = ALU_SRL;
          F_JR: begin
            c          = '0;
            c.jump     = 1'b1;
            c.jump_src = 2'b10;
          end
          default: begin
            c         = '0;
            c.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
      OP_ANDI:           begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_AND; end
      OP_ORI:            begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_OR;  end
      OP_XORI:           begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_XOR; end
      OP_LUI:            begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_LUI; end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_op     = ALU_ADD;
      end
      OP_SW:   begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.alu_op = ALU_ADD; end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BR_A, OP_BR_B: c.branch = 1'b1;
      OP_J:    c.jump = 1'b1;
      OP_JAL:  begin c.jump = 1'b1; c.reg_write = 1'b1; end
`ifdef DECODE_FP_EN
      OP_ADD_S: begin c.is_float = 1'b1; c.alu_op = 4'b0001; c.reg_write = 1'b1; end
      OP_SUB_S: begin c.is_float = 1'b1; c.alu_op = 4'b0010; c.reg_write = 1'b1; end
      OP_CEQ_S: begin c.is_float = 1'b1; c.alu_op = 4'b0011; end
      OP_CLT_S: begin c.is_float = 1'b1; c.alu_op = 4'b0100; end
      OP_CLE_S: begin c.is_float = 1'b1; c.alu_op = 4'b0101; end
      OP_MOV_S: begin c.is_float = 1'b1; c.alu_op = 4'b0110; c.reg_write = 1'b1; end
      OP_MFC1:  begin c.is_float = 1'b1; c.mfc1 = 1'b1; c.reg_write = 1'b1; end
      OP_MTC1:  begin c.is_float = 1'b1; c.mtc1 = 1'b1; end
`endif
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Instructions whose rt field is a source operand (rs is always a source)
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) ||
           (op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BR_A, OP_BR_B});
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_queue_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : decode_queue_stage_if                                        |
// | Description : Fetch-side and execute-side handshakes, flush and stall      |
// |               counter of the decode queue stage.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface decode_queue_stage_if #(
  parameter int CNT_W = 16
);
  logic                              in_valid;
  logic                              in_ready;
  logic [31:0]                       in_instr;
  logic [31:0]                       in_pc_plus_4;
  logic                              flush;
  logic                              out_valid;
  logic                              out_ready;
  logic [31:0]                       out_instr;
  logic [31:0]                       out_pc_plus_4;
  logic [mips_decode_pkg::CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]                  stall_cnt;

  // Surrounding pipeline (fetch + execute) view
  modport master (
    output in_valid, in_instr, in_pc_plus_4, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc_plus_4, out_ctrl, stall_cnt
  );

  // Decode stage view
  modport slave (
    input  in_valid, in_instr, in_pc_plus_4, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc_plus_4, out_ctrl, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/decode_queue_stage_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decode_queue_fifo                                            |
// | Description : Synchronous FIFO with full/empty flags and a flush that      |
// |               empties it on the next edge. DEPTH is a power of 2, >= 2.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module decode_queue_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_flush,
  input  wire logic              i_push,
  input  wire logic              i_pop,
  input  wire logic [DATA_W-1:0] i_data,
  output logic      [DATA_W-1:0] o_data,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int c_AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_AW:0]     r_wr_ptr;
  logic [c_AW:0]     r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  // Pointers carry one extra wrap bit to tell full from empty
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign o_data    = r_mem[r_rd_ptr[c_AW-1:0]];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  // Storage write; contents need no reset since empty hides them
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end
  end

  // Pointer update with reset and flush returning both pointers to zero
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/decode_queue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decode_queue_stage                                           |
// | Description : Registered mini-MIPS decode stage: instruction FIFO, decoded |
// |               output register, load-use bubble, flush, stall counter.      |
// |               FP opcode decoding is enabled by macro DECODE_FP_EN.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module decode_queue_stage
  import mips_decode_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input wire logic              clk,
  input wire logic              rst_n,
  decode_queue_stage_if.slave   bus
);
  logic        w_full;
  logic        w_empty;
  logic        w_in_ready;
  logic        w_push;
  logic [63:0] w_head_data;
  logic [31:0] w_head_instr;
  logic [31:0] w_head_pc;
  ctrl_t       w_head_ctrl;
  logic [4:0]  w_ld_rt;
  logic        w_depart;
  logic        w_hazard;
  logic        w_load;

  logic             r_out_valid;
  logic [31:0]      r_out_instr;
  logic [31:0]      r_out_pc;
  ctrl_t            r_out_ctrl;
  logic [CNT_W-1:0] r_stall_cnt;

  decode_queue_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (64)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.flush),
    .i_push  (w_push),
    .i_pop   (w_load),
    .i_data  ({bus.in_instr, bus.in_pc_plus_4}),
    .o_data  (w_head_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_instr = w_head_data[63:32];
  assign w_head_pc    = w_head_data[31:0];
  assign w_head_ctrl  = decode(w_head_instr[31:26], w_head_instr[5:0]);

  assign w_in_ready = rst_n && !w_full && !bus.flush;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_depart   = r_out_valid && bus.out_ready;

  // Load-use: departing lw writes a register the head needs next cycle
  assign w_ld_rt  = r_out_instr[20:16];
  assign w_hazard = !w_empty && w_depart && r_out_ctrl.mem_read && (w_ld_rt != 5'd0) &&
                    ((w_head_instr[25:21] == w_ld_rt) ||
                     (reads_rt(w_head_instr[31:26]) && (w_head_instr[20:16] == w_ld_rt)));
  assign w_load   = !w_empty && (!r_out_valid || bus.out_ready) && !w_hazard && !bus.flush;

  // Output register: flush beats load, load beats plain departure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
      r_out_ctrl  <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_instr <= w_head_instr;
      r_out_pc    <= w_head_pc;
      r_out_ctrl  <= w_head_ctrl;
    end else if (w_depart) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating count of inserted load-use bubbles; survives flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && !bus.flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_instr     = r_out_instr;
  assign bus.out_pc_plus_4 = r_out_pc;
  assign bus.out_ctrl      = r_out_ctrl;
  assign bus.stall_cnt     = r_stall_cnt;
endmodule
`default_nettype wire
